decrip_rx: RTL and testbench
============================

Name: decrip_rx

Overview:
- Receive-side decryptor for the 5-bit ENCRIP code-word stream: it checks parity, finds a sync word, and XORs each data word with a rolling 3-bit keystream to recover the 3-bit plaintext.
- Sits directly behind the encryptor's 5-bit output (or after a channel carrying it) and feeds plaintext to downstream logic.
- Single clock domain; all outputs are registered.

Parameters:
- KEY_SEED, 3'b101, keystream value loaded on sync. Must be nonzero.
- ERR_LIMIT, 3, consecutive parity errors in RUN that force a return to HUNT. Range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- Ein_valid  input  1  Ein carries a word this cycle.
- Ein  input  5  code word: [4] even parity over [3:0]; [3] sync flag; [2:0] cipher.
- Dout  output  3  recovered plaintext.
- Dout_valid  output  1  one-cycle strobe qualifying Dout.
- err  output  1  one-cycle strobe on a parity error.
- locked  output  1  high while in RUN.

Behaviour:
- Interface: one clock, clk; reset nRST is asynchronous and active-low.
- Reset values: Dout=0, Dout_valid=0, err=0, locked=0, state=HUNT, key=KEY_SEED, errcnt=0.
- Parity check: parity_ok = ^Ein[4:0] == 0.
- Sync word: Ein[3]=1 and Ein[2:0]=3'b000 and parity_ok. The only sync word with correct parity is Ein=5'b11000.
- Keystream: 3-bit LFSR, next = {k[1:0], k[2]^k[1]}, period 7. Sequence from 101: 101, 011, 111, 110, 100, 001, 010, 101.
- Cycles with Ein_valid=0 change nothing; the strobes are driven 0.
- HUNT state:
  - A valid sync word loads key=KEY_SEED, clears errcnt, and moves to RUN (locked=1 the next cycle).
  - Every other valid word is dropped silently: no err, no Dout_valid.
- RUN state, valid data word (Ein[3]=0, parity_ok):
  - Next cycle: Dout = Ein[2:0] ^ key, Dout_valid=1.
  - key advances; errcnt clears.
- RUN state, valid word with a parity error:
  - Next cycle: err=1, Dout_valid=0, Dout holds its value.
  - key advances so alignment with the sender is kept; errcnt increments.
  - If errcnt reaches ERR_LIMIT, go to HUNT (locked=0 the next cycle) and clear errcnt.
- RUN state, valid sync word: resynchronise. Reload KEY_SEED, clear errcnt, stay in RUN. No output strobe.
- RUN state, Ein[3]=1 with a nonzero cipher field and parity_ok: treated as a framing error. Same handling as a parity error.
- Latency: exactly 1 clock from a valid input word to Dout_valid or err.
- Dout_valid and err are never high in the same cycle.
- Reset asserted mid-stream: all state returns to the reset values immediately (asynchronous); an in-flight word is lost.

Optional Feature:
- Macro: DECRIP_ERRCNT_EN.
- Defined: adds output port err_total [7:0], a running count of err pulses since reset. It saturates at 8'hFF and is reset to 0 by nRST only; resync does not clear it.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- decrip_pkg holds:
  - the state enum {HUNT, RUN};
  - SYNC_WORD = 5'b11000;
  - the default KEY_SEED constant;
  - function lfsr3_next.
- One sub-module is natural: decrip_lfsr (clk, nRST, load, adv, seed → key), shared with the ENCRIP side so both ends use an identical keystream.

Test Plan:
- Reset, then Ein=5'b11000 valid → locked=1 the next cycle, no Dout_valid.
- After sync, Ein=5'b10100 then 5'b10001 → Dout=3'b001 and then 3'b010, each with Dout_valid one cycle after its input.
- Before any sync, data words 5'b10100 and 5'b00000 → locked=0, Dout_valid=0, err=0 throughout.
- In RUN with ERR_LIMIT=3, send three consecutive words with bad parity (e.g. 5'b00100) → three err pulses, then locked=0. A bad word followed by a good word resets errcnt and stays locked.
- In RUN after two data words, resend 5'b11000 then 5'b10100 → Dout=3'b001 (key reloaded to 101).
- Assert nRST low between clock edges while Ein_valid=1 in RUN → outputs and locked drop to 0 immediately, before the next clock edge. With DECRIP_ERRCNT_EN defined, err_total=0.

Source files
------------

// File: rtl/decrip_pkg.sv
// Shared types and constants for the ENCRIP/DECRIP code-word link.
package decrip_pkg;

  typedef enum logic {StHunt, StRun} state_e;

  localparam logic [4:0] SYNC_WORD        = 5'b11000;
  localparam logic [2:0] KEY_SEED_DEFAULT = 3'b101;

  // Maximal-length 3-bit LFSR step, period 7
  function automatic logic [2:0] lfsr3_next(input logic [2:0] k);
    return {k[1:0], k[2] ^ k[1]};
  endfunction

endpackage

// File: rtl/decrip_lfsr.sv
// 3-bit keystream generator shared by the encryptor and decryptor ends.
module decrip_lfsr
  import decrip_pkg::*;
#(
  parameter logic [2:0] Seed = KEY_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       load_i,
  input  logic       adv_i,
  input  logic [2:0] seed_i,
  output logic [2:0] key_o
);

  logic [2:0] key_q, key_d;

  always_comb begin
    key_d = key_q;
    if (load_i) begin
      key_d = seed_i;
    end else if (adv_i) begin
      key_d = lfsr3_next(key_q);
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      key_q <= Seed;
    end else begin
      key_q <= key_d;
    end
  end

  assign key_o = key_q;

endmodule

// File: rtl/decrip_rx.sv
// Receive-side decryptor: parity check, sync hunt, keystream XOR.
// Optional running error counter output err_total enabled by DECRIP_ERRCNT_EN.
module decrip_rx
  import decrip_pkg::*;
#(
  parameter logic [2:0]  KEY_SEED  = KEY_SEED_DEFAULT,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       Ein_valid,
  input  logic [4:0] Ein,
  output logic [2:0] Dout,
  output logic       Dout_valid,
  output logic       err,
  output logic       locked
`ifdef DECRIP_ERRCNT_EN
  ,
  output logic [7:0] err_total
`endif
);

  state_e     state_q, state_d;
  logic [2:0] errcnt_q, errcnt_d;
  logic [2:0] dout_q, dout_d;
  logic       dvalid_q, dvalid_d;
  logic       err_q, err_d;
  logic       key_load, key_adv;
  logic [2:0] key;

  logic parity_ok, is_sync, is_data;

  assign parity_ok = ~^Ein;
  assign is_sync   = (Ein == SYNC_WORD);
  assign is_data   = parity_ok & ~Ein[3];

  decrip_lfsr #(
    .Seed(KEY_SEED)
  ) u_lfsr (
    .clk   (clk),
    .nRST  (nRST),
    .load_i(key_load),
    .adv_i (key_adv),
    .seed_i(KEY_SEED),
    .key_o (key)
  );

  always_comb begin
    state_d  = state_q;
    errcnt_d = errcnt_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    err_d    = 1'b0;
    key_load = 1'b0;
    key_adv  = 1'b0;
    if (Ein_valid) begin
      unique case (state_q)
        StHunt: begin
          if (is_sync) begin
            key_load = 1'b1;
            errcnt_d = '0;
            state_d  = StRun;
          end
        end
        StRun: begin
          if (is_sync) begin
            key_load = 1'b1;
            errcnt_d = '0;
          end else if (is_data) begin
            dout_d   = Ein[2:0] ^ key;
            dvalid_d = 1'b1;
            key_adv  = 1'b1;
            errcnt_d = '0;
          end else begin
            // Parity or framing error: still advance to stay aligned with the sender
            err_d   = 1'b1;
            key_adv = 1'b1;
            if (32'(errcnt_q) + 32'd1 >= ERR_LIMIT) begin
              state_d  = StHunt;
              errcnt_d = '0;
            end else begin
              errcnt_d = errcnt_q + 3'd1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StHunt;
      errcnt_q <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      errcnt_q <= errcnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
    end
  end

  assign Dout       = dout_q;
  assign Dout_valid = dvalid_q;
  assign err        = err_q;
  assign locked     = (state_q == StRun);

`ifdef DECRIP_ERRCNT_EN
  logic [7:0] err_total_q, err_total_d;

  always_comb begin
    err_total_d = err_total_q;
    if (err_d && err_total_q != 8'hFF) begin
      err_total_d = err_total_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      err_total_q <= '0;
    end else begin
      err_total_q <= err_total_d;
    end
  end

  assign err_total = err_total_q;
`endif

endmodule

// File: tb/tb_decrip_rx.sv
// Randomised self-checking bench for decrip_rx against a keystream-table model.
module tb_decrip_rx;

  localparam int ErrLimit = 3;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic       Ein_valid = 1'b0;
  logic [4:0] Ein = '0;
  logic [2:0] Dout;
  logic       Dout_valid;
  logic       err;
  logic       locked;
`ifdef DECRIP_ERRCNT_EN
  logic [7:0] err_total;
`endif

  decrip_rx #(
    .KEY_SEED (3'b101),
    .ERR_LIMIT(ErrLimit)
  ) dut (
    .clk       (clk),
    .nRST      (nRST),
    .Ein_valid (Ein_valid),
    .Ein       (Ein),
    .Dout      (Dout),
    .Dout_valid(Dout_valid),
    .err       (err),
    .locked    (locked)
`ifdef DECRIP_ERRCNT_EN
    ,
    .err_total (err_total)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Keystream written out as the published sequence rather than as an LFSR
  logic [2:0] keyseq [7] = '{3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001, 3'b010};

  logic [2:0] m_dout = '0;
  logic       m_valid = 1'b0;
  logic       m_err = 1'b0;
  logic       m_locked = 1'b0;
  int         m_idx = 0;
  int         m_cnt = 0;
  int         m_total = 0;
  logic       chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_dout = '0; m_valid = 1'b0; m_err = 1'b0; m_locked = 1'b0;
    m_idx = 0; m_cnt = 0; m_total = 0;
  endtask

  task automatic model_step(input logic v, input logic [4:0] e);
    logic pok, sync;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!v) return;
    pok  = ~^e;
    sync = (e == 5'b11000);
    if (!m_locked) begin
      if (sync) begin
        m_locked = 1'b1; m_idx = 0; m_cnt = 0;
      end
    end else if (sync) begin
      m_idx = 0; m_cnt = 0;
    end else if (pok && !e[3]) begin
      m_dout  = e[2:0] ^ keyseq[m_idx];
      m_valid = 1'b1;
      m_idx   = (m_idx + 1) % 7;
      m_cnt   = 0;
    end else begin
      m_err = 1'b1;
      m_idx = (m_idx + 1) % 7;
      m_cnt++;
      if (m_total < 255) m_total++;
      if (m_cnt >= ErrLimit) begin
        m_locked = 1'b0; m_cnt = 0;
      end
    end
  endtask

  // Drive one word, let the DUT take it, advance the model alongside
  task automatic send(input logic v, input logic [4:0] e);
    Ein_valid = v;
    Ein       = e;
    @(posedge clk);
    model_step(v, e);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("dout", int'(Dout), int'(m_dout));
      check("dout_valid", int'(Dout_valid), int'(m_valid));
      check("err", int'(err), int'(m_err));
      check("locked", int'(locked), int'(m_locked));
`ifdef DECRIP_ERRCNT_EN
      check("err_total", int'(err_total), m_total);
`endif
    end
  end

  function automatic logic [4:0] data_word(input logic [2:0] c);
    return {^c, 1'b0, c};
  endfunction

  initial begin
    model_reset();
    #12;
    check("rst_dout", int'(Dout), 0);
    check("rst_dout_valid", int'(Dout_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_locked", int'(locked), 0);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Pre-sync data words are dropped
    send(1'b1, 5'b10100);
    send(1'b1, 5'b00000);
    send(1'b1, 5'b00100);
    check("hunt_locked", int'(locked), 0);
    check("hunt_err", int'(err), 0);

    send(1'b1, 5'b11000);
    check("sync_locked", int'(locked), 1);
    check("sync_dvalid", int'(Dout_valid), 0);
    send(1'b1, 5'b10100);
    check("d1_valid", int'(Dout_valid), 1);
    check("d1_dout", int'(Dout), 1);
    send(1'b0, 5'b11111);
    check("idle_valid", int'(Dout_valid), 0);
    send(1'b1, 5'b10001);
    check("d2_dout", int'(Dout), 2);

    // Resync reloads the seed
    send(1'b1, 5'b11000);
    send(1'b1, 5'b10100);
    check("resync_dout", int'(Dout), 1);

    // One bad word then a good word keeps lock
    send(1'b1, 5'b00100);
    check("bad_err", int'(err), 1);
    check("bad_hold", int'(Dout), 1);
    send(1'b1, 5'b10100);
    check("recover_dout", int'(Dout), 3);
    check("recover_locked", int'(locked), 1);

    // Framing error, then three parity errors drop lock
    send(1'b1, 5'b01001);
    check("frame_err", int'(err), 1);
    send(1'b1, 5'b10100);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 5'b00100);
      check("burst_err", int'(err), 1);
    end
    check("burst_unlock", int'(locked), 0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [4:0] w;
      r = int'($urandom_range(0, 19));
      w = 5'($urandom);
      if (r < 2)       send(1'b1, 5'b11000);
      else if (r < 5)  send(1'b0, w);
      else if (r < 7)  send(1'b1, w);
      else if (r < 8)  send(1'b1, {~^w[3:0], w[3:0]});
      else             send(1'b1, data_word(w[2:0]));
    end

    // Asynchronous reset mid-stream
    send(1'b1, 5'b11000);
    Ein_valid = 1'b1;
    Ein       = 5'b10100;
    #1;
    nRST = 1'b0;
    model_reset();
    #1;
    check("arst_locked", int'(locked), 0);
    check("arst_dvalid", int'(Dout_valid), 0);
    check("arst_dout", int'(Dout), 0);
    check("arst_err", int'(err), 0);
`ifdef DECRIP_ERRCNT_EN
    check("arst_total", int'(err_total), 0);
`endif
    Ein_valid = 1'b0;
    @(posedge clk);
    #1;
    nRST = 1'b1;
    send(1'b1, 5'b11000);
    send(1'b1, 5'b10100);
    check("post_rst_dout", int'(Dout), 1);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
